// File: rtl/mem_access_unit_if.sv
// Bundle of the request/response handshake and the data-memory port of mem_access_unit.
// slave is the unit's view; master is the view of whatever drives requests and models memory.
interface mem_access_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic [1:0]        resp_err;

  logic [ADDR_W-1:0] mem_address;
  logic              mem_read_write;
  logic [1:0]        mem_access_size;
  logic [31:0]       mem_data_in;
  logic [31:0]       mem_data_out;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_data_out,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_address, mem_read_write, mem_access_size, mem_data_in
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_data_out,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_address, mem_read_write, mem_access_size, mem_data_in
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store front-end: legality check, one memory access, extended registered load response.
// Define MAU_MISALIGN_SPLIT_EN to service misaligned half/word accesses as byte sequences.
module mem_access_unit #(
  parameter int unsigned MEM_DEPTH = 32,
  parameter int unsigned ADDR_W    = 32
) (
  input logic              clk,
  input logic              rst_n,
  mem_access_unit_if.slave bus
);
  localparam int unsigned AW1 = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;
  typedef enum logic [1:0] {
    ERR_OK = 2'b00, ERR_MISALIGN = 2'b01, ERR_RANGE = 2'b10, ERR_FUNCT3 = 2'b11
  } err_e;

  state_e            state_q, state_d;
  logic              store_q, store_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        err_q, err_d;
`ifdef MAU_MISALIGN_SPLIT_EN
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       asm_q, asm_d;
`endif

  logic [1:0]        size;
  logic [1:0]        last_byte;
  logic              illegal, misaligned, out_of_range;
  logic [AW1-1:0]    end_addr;
  err_e              chk_err;

  logic              done;
  logic [31:0]       load_word;
  logic [ADDR_W-1:0] mem_addr_c;
  logic              mem_rw_c;
  logic [1:0]        mem_size_c;
  logic [31:0]       mem_wdata_c;

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] f3);
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b010:  return w;
      3'b100:  return {24'b0, w[7:0]};
      3'b101:  return {16'b0, w[15:0]};
      default: return 32'b0;
    endcase
  endfunction

  // Legality of the captured request; the end address is one bit wider so it cannot wrap.
  always_comb begin
    size         = funct3_q[1:0];
    last_byte    = (size == 2'd0) ? 2'd0 : (size == 2'd1) ? 2'd1 : 2'd3;
    illegal      = store_q ? (funct3_q > 3'b010)
                           : !(funct3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misaligned   = ((size == 2'd1) && addr_q[0]) || ((size == 2'd2) && (addr_q[1:0] != 2'b00));
    end_addr     = {1'b0, addr_q} + AW1'(last_byte);
    out_of_range = end_addr >= AW1'(MEM_DEPTH);
    if (illegal)           chk_err = ERR_FUNCT3;
`ifndef MAU_MISALIGN_SPLIT_EN
    else if (misaligned)   chk_err = ERR_MISALIGN;
`endif
    else if (out_of_range) chk_err = ERR_RANGE;
    else                   chk_err = ERR_OK;
  end

  // NOTE: every variable written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    store_d     = store_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
`ifdef MAU_MISALIGN_SPLIT_EN
    cnt_d       = cnt_q;
    asm_d       = asm_q;
`endif
    done        = 1'b1;
    load_word   = bus.mem_data_out;
    mem_addr_c  = '0;
    mem_rw_c    = 1'b0;
    mem_size_c  = 2'd0;
    mem_wdata_c = 32'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          store_d  = bus.req_store;
          funct3_d = bus.req_funct3;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
`ifdef MAU_MISALIGN_SPLIT_EN
          cnt_d    = 2'd0;
          asm_d    = 32'b0;
`endif
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (chk_err == ERR_OK) begin
`ifdef MAU_MISALIGN_SPLIT_EN
          if (misaligned) begin
            // One byte per pass; load bytes collect little-endian in asm.
            mem_addr_c  = addr_q + ADDR_W'(cnt_q);
            mem_rw_c    = store_q;
            mem_wdata_c = {24'b0, wdata_q[{cnt_q, 3'b000} +: 8]};
            asm_d[{cnt_q, 3'b000} +: 8] = bus.mem_data_out[7:0];
            cnt_d       = cnt_q + 2'd1;
            load_word   = asm_d;
            done        = (cnt_q == last_byte);
          end else
`endif
          begin
            mem_addr_c  = addr_q;
            mem_rw_c    = store_q;
            mem_size_c  = size;
            mem_wdata_c = wdata_q;
          end
        end
        if (done) begin
          err_d   = chk_err;
          rdata_d = ((chk_err == ERR_OK) && !store_q) ? extend(load_word, funct3_q) : 32'b0;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      store_q  <= 1'b0;
      funct3_q <= 3'b0;
      addr_q   <= '0;
      wdata_q  <= 32'b0;
      rdata_q  <= 32'b0;
      err_q    <= 2'b0;
`ifdef MAU_MISALIGN_SPLIT_EN
      cnt_q    <= 2'd0;
      asm_q    <= 32'b0;
`endif
    end else begin
      state_q  <= state_d;
      store_q  <= store_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
`ifdef MAU_MISALIGN_SPLIT_EN
      cnt_q    <= cnt_d;
      asm_q    <= asm_d;
`endif
    end
  end

  assign bus.req_ready       = (state_q == IDLE);
  assign bus.resp_valid      = (state_q == RESP);
  assign bus.resp_rdata      = rdata_q;
  assign bus.resp_err        = err_q;
  assign bus.mem_address     = mem_addr_c;
  assign bus.mem_read_write  = mem_rw_c;
  assign bus.mem_access_size = mem_size_c;
  assign bus.mem_data_in     = mem_wdata_c;
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed plan plus random requests against a byte-array model.
// Follows MAU_MISALIGN_SPLIT_EN the same way the design does.
module tb_mem_access_unit;
  localparam int unsigned MEM_DEPTH = 32;
  localparam int unsigned ADDR_W    = 32;
`ifdef MAU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

  mem_access_unit #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory model: combinational read, byte-enabled write on the clock edge.
  logic [7:0]  mem [MEM_DEPTH] = '{default: 8'h00};
  int          wr_count = 0;
  logic [31:0] mem_rd;

  always_comb begin
    mem_rd = 32'b0;
    for (int i = 0; i < 4; i++) begin
      if (longint'(bus.mem_address) + i < MEM_DEPTH)
        mem_rd[8*i +: 8] = mem[int'(longint'(bus.mem_address) + i)];
      else
        mem_rd[8*i +: 8] = 8'hxx;
    end
  end
  assign bus.mem_data_out = mem_rd;

  always @(posedge clk) begin
    if (bus.mem_read_write === 1'b1) begin
      wr_count <= wr_count + 1;
      for (int i = 0; i < 4; i++)
        if (i < (1 << bus.mem_access_size) && longint'(bus.mem_address) + i < MEM_DEPTH)
          mem[int'(longint'(bus.mem_address) + i)] <= bus.mem_data_in[8*i +: 8];
    end
  end

  logic [7:0] ref_mem [MEM_DEPTH];
  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: architectural effect of one request on the byte array.
  function automatic void model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic [1:0] err,
                                output logic [31:0] rd, output int lat, output int nwr);
    int nb;
    bit legal, mis;
    longint unsigned last_addr;
    logic [31:0] v;
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    nb = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    mis = (a % nb) != 0;
    last_addr = longint'(a) + nb - 1;
    rd = 32'b0; lat = 2; nwr = 0;
    if (!legal) err = 2'b11;
    else if (mis && !SPLIT) err = 2'b01;
    else if (last_addr >= MEM_DEPTH) err = 2'b10;
    else begin
      err = 2'b00;
      if (mis) lat = nb + 1;
      if (st) begin
        for (int i = 0; i < nb; i++) ref_mem[a + i] = wd[8*i +: 8];
        nwr = mis ? nb : 1;
      end else begin
        v = 32'b0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[a + i];
        if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
        rd = v;
      end
    end
  endfunction

  task automatic mem_compare(input string tag);
    int diffs = 0;
    for (int i = 0; i < MEM_DEPTH; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check({tag, ":mem"}, diffs, 0);
  endtask

  // Called at a negedge with the unit idle; returns at the next negedge.
  task automatic run(input string tag, input bit st, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd);
    logic [1:0]  e_err;
    logic [31:0] e_rd;
    int e_lat, e_nwr, lat, wr0;
    bit seen;
    model(st, f3, a, wd, e_err, e_rd, e_lat, e_nwr);
    check({tag, ":ready"}, bus.req_ready, 1);
    bus.req_valid = 1'b1; bus.req_store = st; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = wd;
    wr0 = wr_count;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1; seen = 1'b0;
    while (!seen && lat < 8) begin
      @(posedge clk); #1;
      lat++;
      if (bus.resp_valid === 1'b1) seen = 1'b1;
    end
    check({tag, ":latency"}, lat, e_lat);
    check({tag, ":err"}, bus.resp_err, e_err);
    check({tag, ":rdata"}, bus.resp_rdata, e_rd);
    @(posedge clk); #1;
    check({tag, ":strobe_1cyc"}, bus.resp_valid, 0);
    check({tag, ":ready_back"}, bus.req_ready, 1);
    check({tag, ":rdata_hold"}, bus.resp_rdata, e_rd);
    check({tag, ":rw_idle"}, bus.mem_read_write, 0);
    check({tag, ":writes"}, wr_count - wr0, e_nwr);
    @(negedge clk);
    mem_compare(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    int wr0, ones;
    for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = 8'h00;
    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = 3'b0;
    bus.req_addr = '0; bus.req_wdata = 32'b0;

    repeat (3) @(negedge clk);
    check("rst:req_ready", bus.req_ready, 1);
    check("rst:resp_valid", bus.resp_valid, 0);
    check("rst:resp_rdata", bus.resp_rdata, 0);
    check("rst:resp_err", bus.resp_err, 0);
    check("rst:mem_address", bus.mem_address, 0);
    check("rst:mem_rw", bus.mem_read_write, 0);
    check("rst:mem_size", bus.mem_access_size, 0);
    check("rst:mem_data_in", bus.mem_data_in, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run("sw08", 1, 3'b010, 32'h08, 32'hDEADBEEF);
    run("lw08", 0, 3'b010, 32'h08, 32'h0);
    run("lb08", 0, 3'b000, 32'h08, 32'h0);
    run("lbu08", 0, 3'b100, 32'h08, 32'h0);
    run("lh0a", 0, 3'b001, 32'h0A, 32'h0);
    run("lhu0a", 0, 3'b101, 32'h0A, 32'h0);
    run("lw06", 0, 3'b010, 32'h06, 32'h0);
    run("lw1e", 0, 3'b010, 32'h1E, 32'h0);
    run("ld011", 0, 3'b011, 32'h00, 32'h0);
    run("st100", 1, 3'b100, 32'h00, 32'h0);
    run("sw1c_edge", 1, 3'b010, 32'h1C, 32'hCAFEF00D);
    run("lb1f_edge", 0, 3'b000, 32'h1F, 32'h0);
    run("lh1f_edge", 0, 3'b001, 32'h1F, 32'h0);
    run("lbffff", 0, 3'b000, 32'hFFFF_FFFF, 32'h0);
    run("lw_nowrap", 0, 3'b010, 32'hFFFF_FFFE, 32'h0);

    // Reset pulse while the store is in ISSUE: no write, no response.
    bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h12345678;
    wr0 = wr_count;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rstmid:mem_rw", bus.mem_read_write, 0);
    check("rstmid:mem_address", bus.mem_address, 0);
    check("rstmid:mem_data_in", bus.mem_data_in, 0);
    check("rstmid:req_ready", bus.req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rstmid:writes", wr_count - wr0, 0);
    ones = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.resp_valid !== 1'b0) ones++;
    end
    check("rstmid:no_resp", ones, 0);
    check("rstmid:ready_after", bus.req_ready, 1);
    @(negedge clk);
    mem_compare("rstmid");

    run("sh05", 1, 3'b001, 32'h05, 32'h00001234);
    run("lh05", 0, 3'b001, 32'h05, 32'h0);
    run("sw0d", 1, 3'b010, 32'h0D, 32'h89ABCDEF);
    run("lw0d", 0, 3'b010, 32'h0D, 32'h0);

    for (int k = 0; k < 40; k++) begin
      bit          st;
      logic [2:0]  f3;
      logic [31:0] a, wd;
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, MEM_DEPTH + 4));
      wd = $urandom;
      run($sformatf("rnd%0d", k), st, f3, a, wd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
